// File: rtl/ysyx_24090005_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ysyx_24090005_imem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Fibonacci taps 8,6,5,4 expressed as a bit mask over lfsr[7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_24090005_imem_resp_if.sv
// Fetch bus between the fetch unit (master) and the instruction memory (slave).
interface ysyx_24090005_imem_resp_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  modport master (
    output ar_valid, ar_addr, r_ready,
    input  ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready,
    output ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/ysyx_24090005_imem_lat_gen.sv
// Per-request latency source: fixed LATENCY, or LFSR-driven 1..8 when
// YSYX_24090005_IMEM_RANDOM_DELAY_EN is defined.
module ysyx_24090005_imem_lat_gen
  import ysyx_24090005_imem_pkg::*;
#(
  parameter int         LATENCY   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  output logic [3:0] lat
);

`ifdef YSYX_24090005_IMEM_RANDOM_DELAY_EN
  logic [7:0] lfsr_reg;
  logic       unused_ok;

  // Free-running: the value seen on the acceptance cycle picks the latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign lat       = 4'd1 + {1'b0, lfsr_reg[2:0]};
  assign unused_ok = ^{accept, 4'(LATENCY)};
`else
  logic unused_ok;

  assign lat       = 4'(LATENCY);
  assign unused_ok = ^{clk, rst, accept, LFSR_SEED};
`endif

endmodule

// File: rtl/ysyx_24090005_imem_resp.sv
// Instruction-memory responder: one outstanding fetch, programmable latency,
// side preload port. Optional random latency via YSYX_24090005_IMEM_RANDOM_DELAY_EN.
module ysyx_24090005_imem_resp
  import ysyx_24090005_imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_24090005_imem_resp_if.slave       bus,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [31:0]                    ld_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state_reg;
  logic [3:0]       cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             ok_reg;
  logic             r_valid_reg;
  logic [1:0]       r_resp_reg;
  logic             data_ok_reg;
  logic [31:0]      rd_word_reg;

  logic [31:0] offset;
  logic        addr_ok;
  logic        ar_ready;
  logic        accept;
  logic        rd_en;
  logic [3:0]  lat;
  logic        unused_offset;

  assign offset        = bus.ar_addr - BASE_ADDR;
  assign addr_ok       = (bus.ar_addr[1:0] == 2'b00) && (offset[31:IDX_W+2] == '0);
  assign unused_offset = ^offset[1:0];

  assign ar_ready = (state_reg == IDLE) && !rst;
  assign accept   = bus.ar_valid && ar_ready;
  assign rd_en    = !rst && (state_reg == WAIT) && (cnt_reg == 4'd0);

  ysyx_24090005_imem_lat_gen #(
    .LATENCY   (LATENCY),
    .LFSR_SEED (LFSR_SEED)
  ) u_lat_gen (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .lat    (lat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= '0;
      ok_reg      <= 1'b0;
      r_valid_reg <= 1'b0;
      r_resp_reg  <= RESP_OKAY;
      data_ok_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            idx_reg   <= offset[IDX_W+1:2];
            ok_reg    <= addr_ok;
            cnt_reg   <= lat - 4'd1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            r_valid_reg <= 1'b1;
            r_resp_reg  <= ok_reg ? RESP_OKAY : RESP_SLVERR;
            data_ok_reg <= ok_reg;
            state_reg   <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.r_ready) begin
            r_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array kept free of reset so it maps to block RAM; a same-edge load
  // to the word being read returns the old contents.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
    if (rd_en) begin
      rd_word_reg <= mem[idx_reg];
    end
  end

  assign bus.ar_ready = ar_ready;
  assign bus.r_valid  = r_valid_reg;
  assign bus.r_resp   = r_resp_reg;
  assign bus.r_data   = data_ok_reg ? rd_word_reg : 32'h0;

endmodule

// File: tb/tb_ysyx_24090005_imem_resp.sv
// Directed bench: three responders with LATENCY 1, 2, 3 share load/address
// stimulus; each has its own request and response handshake.
module tb_ysyx_24090005_imem_resp;
  import ysyx_24090005_imem_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  ar_valid;
  logic [2:0]  r_ready;
  logic [31:0] ar_addr;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [31:0] ld_data;

  logic [2:0]  o_ar_ready;
  logic [2:0]  o_r_valid;
  logic [31:0] o_r_data [3];
  logic [1:0]  o_r_resp [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      ysyx_24090005_imem_resp_if bus ();
      assign bus.ar_valid    = ar_valid[gi];
      assign bus.ar_addr     = ar_addr;
      assign bus.r_ready     = r_ready[gi];
      assign o_ar_ready[gi]  = bus.ar_ready;
      assign o_r_valid[gi]   = bus.r_valid;
      assign o_r_data[gi]    = bus.r_data;
      assign o_r_resp[gi]    = bus.r_resp;

      ysyx_24090005_imem_resp #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h8000_0000),
        .LATENCY     (gi + 1),
        .LFSR_SEED   (8'hA5)
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
      );
    end
  endgenerate

`ifdef YSYX_24090005_IMEM_RANDOM_DELAY_EN
  logic [7:0] ref_lfsr;
  always @(posedge clk) begin
    if (rst) ref_lfsr <= 8'hA5;
    else     ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end
`endif

  // Latency the responder will pick if it accepts at the coming edge.
  function automatic int exp_lat(input int sel);
`ifdef YSYX_24090005_IMEM_RANDOM_DELAY_EN
    return 1 + int'(ref_lfsr[2:0]);
`else
    return sel + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fetch(input int sel, input logic [31:0] addr, input bit rr_early,
                       input int stall, input bit pulse,
                       output logic [31:0] data, output logic [1:0] resp, output int lat);
    int e;
    int n;
    check("ar_ready_idle", {31'b0, o_ar_ready[sel]}, 32'd1);
    e = exp_lat(sel);
    ar_addr = addr; ar_valid[sel] = 1'b1; r_ready[sel] = rr_early;
    @(posedge clk); #1;
    ar_valid[sel] = 1'b0;
    n = 0;
    do begin
      if (pulse) begin ar_valid[sel] = 1'b1; ar_addr = 32'h8000_0010; end
      @(posedge clk); #1;
      n++;
    end while (!o_r_valid[sel] && n < 40);
    lat = n;
    check("latency", n, e);
    data = o_r_data[sel];
    resp = o_r_resp[sel];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'b0, o_r_valid[sel]}, 32'd1);
      check("stall_data", o_r_data[sel], data);
      check("stall_resp", {30'b0, o_r_resp[sel]}, {30'b0, resp});
      check("stall_ar_ready", {31'b0, o_ar_ready[sel]}, 32'd0);
    end
    ar_valid[sel] = 1'b0; r_ready[sel] = 1'b1;
    @(posedge clk); #1;
    r_ready[sel] = 1'b0;
    check("post_hs_valid", {31'b0, o_r_valid[sel]}, 32'd0);
    check("post_hs_ar_ready", {31'b0, o_ar_ready[sel]}, 32'd1);
    $display("fetch dut=%0d addr=%h data=%h resp=%b lat=%0d", sel, addr, data, resp, lat);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    int          l;
    int          e;
    int          n;
    logic [31:0] words [4];

    rst = 1'b1; ar_valid = '0; r_ready = '0; ar_addr = '0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_valid", {31'b0, o_r_valid[0]}, 32'd0);
    check("rst_ar_ready", {31'b0, o_ar_ready[0]}, 32'd0);
    check("rst_r_data", o_r_data[0], 32'h0);
    check("rst_r_resp", {30'b0, o_r_resp[0]}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ar_ready", {31'b0, o_ar_ready[0]}, 32'd1);

    load(12'd0, 32'h0000_0413);
    load(12'd1, 32'h00A0_0093);
    load(12'd3, 32'h3333_3333);
    load(12'd4095, 32'hDEAD_BEEF);

    // 1: LATENCY=1, r_ready held high.
    fetch(0, 32'h8000_0000, 1'b1, 0, 1'b0, d, rs, l);
    check("t1_data", d, 32'h0000_0413);
    check("t1_resp", {30'b0, rs}, 32'd0);

    // 2: LATENCY=3, five-cycle stall with ignored request pulses.
    fetch(2, 32'h8000_0004, 1'b0, 5, 1'b1, d, rs, l);
    check("t2_data", d, 32'h00A0_0093);
    check("t2_resp", {30'b0, rs}, 32'd0);

    // 3: error decode.
    fetch(0, 32'h8000_0002, 1'b1, 0, 1'b0, d, rs, l);
    check("misalign_resp", {30'b0, rs}, {30'b0, RESP_SLVERR});
    check("misalign_data", d, 32'h0);
    fetch(0, 32'h8000_4000, 1'b1, 0, 1'b0, d, rs, l);
    check("above_resp", {30'b0, rs}, {30'b0, RESP_SLVERR});
    check("above_data", d, 32'h0);
    fetch(0, 32'h7FFF_FFFC, 1'b1, 0, 1'b0, d, rs, l);
    check("below_resp", {30'b0, rs}, {30'b0, RESP_SLVERR});
    fetch(0, 32'h8000_3FFC, 1'b1, 0, 1'b0, d, rs, l);
    check("last_resp", {30'b0, rs}, 32'd0);
    check("last_data", d, 32'hDEAD_BEEF);

    // 4a: load on the registering edge is not visible.
    load(12'd2, 32'h1111_1111);
    e = exp_lat(1);
    ar_addr = 32'h8000_0008; ar_valid[1] = 1'b1;
    @(posedge clk); #1;
    ar_valid[1] = 1'b0;
    repeat (e - 1) begin @(posedge clk); #1; end
    ld_en = 1'b1; ld_idx = 12'd2; ld_data = 32'h2222_2222;
    @(posedge clk); #1;
    ld_en = 1'b0;
    check("race_late_valid", {31'b0, o_r_valid[1]}, 32'd1);
    check("race_late_data", o_r_data[1], 32'h1111_1111);
    $display("race late-load data=%h", o_r_data[1]);
    r_ready[1] = 1'b1;
    @(posedge clk); #1;
    r_ready[1] = 1'b0;

    // 4b: load on the acceptance edge is visible.
    load(12'd2, 32'h1111_1111);
    e = exp_lat(1);
    ar_addr = 32'h8000_0008; ar_valid[1] = 1'b1;
    ld_en = 1'b1; ld_idx = 12'd2; ld_data = 32'h2222_2222;
    @(posedge clk); #1;
    ar_valid[1] = 1'b0; ld_en = 1'b0;
    repeat (e) begin @(posedge clk); #1; end
    check("race_early_valid", {31'b0, o_r_valid[1]}, 32'd1);
    check("race_early_data", o_r_data[1], 32'h2222_2222);
    $display("race accept-load data=%h", o_r_data[1]);
    r_ready[1] = 1'b1;
    @(posedge clk); #1;
    r_ready[1] = 1'b0;

    // 5: reset while the response is pending.
    ar_addr = 32'h8000_0004; ar_valid[0] = 1'b1;
    @(posedge clk); #1;
    ar_valid[0] = 1'b0;
    n = 0;
    while (!o_r_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    check("t5_pending", {31'b0, o_r_valid[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_valid", {31'b0, o_r_valid[0]}, 32'd0);
    check("t5_rst_ar_ready", {31'b0, o_ar_ready[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5_rel_ar_ready", {31'b0, o_ar_ready[0]}, 32'd1);
    $display("reset abort r_valid=%b ar_ready=%b", o_r_valid[0], o_ar_ready[0]);
    fetch(0, 32'h8000_0004, 1'b1, 0, 1'b0, d, rs, l);
    check("t5_reread", d, 32'h00A0_0093);

    // 6: back-to-back fetches (random latency when the feature is built in).
    words[0] = 32'h0000_0413; words[1] = 32'h00A0_0093;
    words[2] = 32'h2222_2222; words[3] = 32'h3333_3333;
    for (int i = 0; i < 20; i++) begin
      fetch(2, 32'h8000_0000 + 32'(4 * (i % 4)), 1'b1, 0, 1'b0, d, rs, l);
      check("b2b_data", d, words[i % 4]);
      check("b2b_resp", {30'b0, rs}, 32'd0);
`ifdef YSYX_24090005_IMEM_RANDOM_DELAY_EN
      check("b2b_lat_range", {31'b0, (l >= 1 && l <= 8)}, 32'd1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_24090005_imem_resp.md
Name: ysyx_24090005_imem_resp

Overview:
Instruction-memory responder. It is the memory side of the fetch interface: it accepts read requests from the fetch unit on an address channel and returns 32-bit instruction words on a data channel after a programmable latency.
- One outstanding request at a time.
- The word array is preloaded through a side load port by the bench or loader.
- It replaces the fetch unit's ideal zero-latency instruction read, so that the multi-cycle fetch FSM can be exercised.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the array; must be a power of 2.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from address acceptance to r_valid; legal range 1..15.
- LFSR_SEED, 8'hA5: initial LFSR value; nonzero; used only with RANDOM_DELAY_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ar_valid  in  1  read request valid.
- ar_ready  out  1  responder can accept a request.
- ar_addr  in  32  byte address of the requested instruction.
- r_valid  out  1  response valid.
- r_ready  in  1  requester accepts the response.
- r_data  out  32  instruction word.
- r_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- ld_en  in  1  preload write strobe.
- ld_idx  in  log2(DEPTH_WORDS)  preload word index.
- ld_data  in  32  preload word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ar_ready=0 while rst=1, r_valid=0, r_data=0, r_resp=0, latency counter=0, LFSR=LFSR_SEED. The memory array is NOT reset.
- States:
  - IDLE: ar_ready=1 (when rst=0). On ar_valid&&ar_ready, latch ar_addr, load cnt=lat-1, go to WAIT.
  - WAIT: ar_ready=0. If cnt==0, perform the array read and error check, register r_data/r_resp, set r_valid=1 and go to RESP. Otherwise decrement cnt.
  - RESP: ar_ready=0. r_valid, r_data and r_resp are held stable until r_ready=1. On r_valid&&r_ready, clear r_valid and go to IDLE.
- Timing:
  - With request accepted at edge T, r_valid is high after edge T+lat, where lat=LATENCY.
  - ar_ready returns high one cycle after the response handshake.
  - Minimum turnaround is lat+2 cycles per fetch.
- Address decode:
  - off = ar_addr - BASE_ADDR (32-bit wrap).
  - The request is OK iff ar_addr[1:0]==0 and off < 4*DEPTH_WORDS.
  - idx = off[log2(DEPTH_WORDS)+1:2].
  - OK: r_data=mem[idx], r_resp=2'b00.
  - Error (misaligned or out of range): r_data=32'h0, r_resp=2'b10. No other side effect.
- Load port:
  - ld_en writes mem[ld_idx]=ld_data at the edge, in any state.
  - A load to the word being read on the same edge the read is registered (the WAIT to RESP edge) is not visible; old data is returned.
  - A load on any earlier edge is visible.
- ar_valid while not in IDLE is ignored and not queued.
- r_ready while r_valid=0 has no effect.
- ar_addr is sampled only at acceptance; later changes are ignored.
- rst asserted mid-transaction aborts it: the next cycle is IDLE with r_valid=0, and no response is ever returned for the aborted request.

Optional Feature:
- Macro: YSYX_24090005_IMEM_RANDOM_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle when rst=0.
  - At each acceptance, lat = 1 + lfsr[2:0] (range 1..8) and the LATENCY parameter is ignored.
  - The sequence is deterministic from LFSR_SEED.
- Undefined: lat = LATENCY always; no LFSR is instantiated.

Decomposition:
- Shared package ysyx_24090005_imem_pkg:
  - resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - state encoding IDLE/WAIT/RESP (2 bits);
  - LFSR tap constant.
- One sub-module: ysyx_24090005_imem_lat_gen.
  - Inputs: clk, rst, accept.
  - Output: lat (4 bits).
  - Contains the LFSR or the fixed constant, selected by the macro.
  - The responder FSM and array stay in the top module.

Test Plan:
1. LATENCY=1: preload idx0=32'h0000_0413, request 32'h8000_0000 with r_ready held at 1 -> r_valid one cycle after acceptance with data 32'h0000_0413, resp 00; ar_ready high again the cycle after the handshake.
2. LATENCY=3: request 32'h8000_0004 (idx1=32'h00A0_0093) with r_ready=0 for 5 cycles -> r_valid appears 3 cycles after acceptance; data and resp stay constant through the stall; ar_valid pulses during WAIT/RESP are ignored.
3. Error cases:
   - 32'h8000_0002 -> resp 10, data 0.
   - 32'h8000_4000 (DEPTH_WORDS=4096) -> resp 10.
   - 32'h7FFF_FFFC -> resp 10.
   - 32'h8000_3FFC -> resp 00, data = mem[4095].
4. Load/read race, LATENCY=2: load idx2=32'h1111_1111, request 32'h8000_0008, then load idx2=32'h2222_2222 on the WAIT to RESP edge -> returns 32'h1111_1111. Loading on the acceptance edge instead -> returns 32'h2222_2222.
5. Reset during RESP with r_valid=1 -> next cycle r_valid=0 and ar_ready=0 while rst=1, then ar_ready=1; memory contents survive and a re-read returns the same data.
6. With RANDOM_DELAY_EN defined, seed 8'hA5, 20 back-to-back fetches -> every latency is in 1..8, the latency sequence matches the reference LFSR model, and all data is correct.
